// File: rtl/mem_arbiter.sv
// Arbitrates a single-port 32-bit memory between instruction fetch and load/store.
// Data wins contention, but fetch is forced through after MAX_DATA_RUN back-to-back data grants.
module mem_arbiter #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);

  state_t      state_reg, state_next;
  logic [3:0]  run_cnt_reg, run_cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [3:0]  data_wstrb;
  logic        grant_fetch, grant_data;

  // Loads never carry byte enables to memory.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wstrb
      assign data_wstrb[gi] = d_we & d_wstrb[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      run_cnt_reg <= 4'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      we_reg      <= 1'b0;
      wstrb_reg   <= 4'd0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      we_reg      <= we_next;
      wstrb_reg   <= wstrb_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    run_cnt_next = run_cnt_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    we_next      = we_reg;
    wstrb_next   = wstrb_reg;
    grant_fetch  = 1'b0;
    grant_data   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (d_req && (!if_req || run_cnt_reg < RUN_LIMIT)) begin
          grant_data = 1'b1;
        end else if (if_req) begin
          grant_fetch = 1'b1;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (grant_data) begin
      state_next = DATA;
      addr_next  = d_addr;
      we_next    = d_we;
      wdata_next = d_wdata;
      wstrb_next = data_wstrb;
      // Only a waiting fetch makes a data grant count towards the starvation limit.
      if (!if_req) begin
        run_cnt_next = 4'd0;
      end else if (run_cnt_reg >= RUN_LIMIT) begin
        run_cnt_next = RUN_LIMIT;
      end else begin
        run_cnt_next = run_cnt_reg + 4'd1;
      end
    end

    if (grant_fetch) begin
      state_next   = FETCH;
      addr_next    = {if_addr[31:2], 2'b00};
      we_next      = 1'b0;
      wdata_next   = 32'd0;
      wstrb_next   = 4'd0;
      run_cnt_next = 4'd0;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign mem_req   = busy;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wstrb = wstrb_reg;

  // A completion coinciding with reset is dropped along with the transaction.
  assign if_ready = (state_reg == FETCH) && mem_ready && !rst;
  assign d_ready  = (state_reg == DATA) && mem_ready && !rst;
  assign if_rdata = if_ready ? mem_rdata : 32'd0;
  assign d_rdata  = d_ready ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level model
// of the fetch/data arbitration rules.
module tb_mem_arbiter;

  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, busy;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_fails  = 0;

  mem_arbiter #(.MAX_DATA_RUN(MAXR)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int          m_owner;   // 0 = none, 1 = fetch, 2 = data
  int          m_streak;  // data grants in a row taken while a fetch was waiting
  int          lat_left;
  logic [31:0] e_addr, e_wdata;
  logic        e_we, exp_if, exp_d, done_if, done_d, fetch_turn;
  logic [3:0]  e_wstrb;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

    // Reset state
    tick; tick;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_mem_wdata", mem_wdata, 32'd0);
    chk32("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'd0);
    chk32("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    $display("txn reset: done");

    // Single fetch, unaligned address, 1-cycle memory
    tick;
    if_req = 1'b1; if_addr = 32'h0000_0006;
    tick;
    chk1("fetch_mem_req", mem_req, 1'b1);
    chk32("fetch_mem_addr", mem_addr, 32'h0000_0004);
    chk1("fetch_mem_we", mem_we, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    #1;
    chk1("fetch_if_ready", if_ready, 1'b1);
    chk32("fetch_if_rdata", if_rdata, 32'h0050_0093);
    chk1("fetch_d_ready", d_ready, 1'b0);
    tick;
    if_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk1("fetch_if_ready_once", if_ready, 1'b0);
    chk1("fetch_idle", mem_req, 1'b0);
    $display("txn fetch addr=00000006 rdata=%h", 32'h0050_0093);

    // Store, 3-cycle memory
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk1("store_mem_req", mem_req, 1'b1);
      chk32("store_mem_addr", mem_addr, 32'h100);
      chk1("store_mem_we", mem_we, 1'b1);
      chk32("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk32("store_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
      mem_ready = (i == 2); mem_rdata = 32'h1234_5678;
      #1;
      chk1("store_d_ready", d_ready, i == 2);
      if (i < 2) tick;
    end
    tick;
    d_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk1("store_idle", mem_req, 1'b0);
    $display("txn store addr=00000100 wdata=deadbeef wstrb=0011");

    // Load with all byte enables set
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_wstrb = 4'b1111;
    tick;
    chk32("load_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk1("load_mem_we", mem_we, 1'b0);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0F0F;
    #1;
    chk1("load_d_ready", d_ready, 1'b1);
    chk32("load_d_rdata", d_rdata, 32'hA5A5_0F0F);
    tick;
    d_req = 1'b0; mem_ready = 1'b0;
    $display("txn load addr=00000104 rdata=a5a50f0f");

    // Contention: both requesters held, expect D,D,D,D,F repeating
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      tick;
      exp_if = (k % (MAXR + 1)) == MAXR;
      chk1("cont_mem_req", mem_req, 1'b1);
      chk32("cont_mem_addr", mem_addr, exp_if ? 32'h200 : 32'h300);
      mem_ready = 1'b1; mem_rdata = 32'(k);
      #1;
      chk1("cont_if_ready", if_ready, exp_if);
      chk1("cont_d_ready", d_ready, !exp_if);
      $display("txn contention grant %0d -> %s", k, if_ready ? "F" : "D");
      tick;
      mem_ready = 1'b0;
      if (k == 9) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      #1;
      chk1("cont_gap", mem_req, 1'b0);
    end

    // Requester drops request and changes address right after grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick;
    d_req = 1'b0; d_addr = 32'h999;
    #1;
    chk32("drop_mem_addr", mem_addr, 32'h40);
    chk1("drop_d_ready_early", d_ready, 1'b0);
    tick;
    mem_ready = 1'b1; mem_rdata = 32'h0000_BEEF;
    #1;
    chk32("drop_mem_addr2", mem_addr, 32'h40);
    chk1("drop_d_ready", d_ready, 1'b1);
    tick;
    mem_ready = 1'b0;
    #1;
    chk1("drop_d_ready_once", d_ready, 1'b0);
    chk1("drop_idle", mem_req, 1'b0);
    $display("txn drop addr=00000040 completed");

    // Reset in cycle 2 of a slow data access, coinciding with mem_ready
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick;
    d_req = 1'b0;
    tick;
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk1("rstmid_no_ready", d_ready, 1'b0);
    tick;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    chk1("rstmid_mem_req", mem_req, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_d_ready", d_ready, 1'b0);
    if_req = 1'b1; if_addr = 32'h13;
    tick;
    chk1("rstmid_fetch_req", mem_req, 1'b1);
    chk32("rstmid_fetch_addr", mem_addr, 32'h10);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    chk1("rstmid_if_ready", if_ready, 1'b1);
    chk32("rstmid_if_rdata", if_rdata, 32'hCAFE_0001);
    tick;
    if_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk1("rstmid_if_once", if_ready, 1'b0);
    $display("txn reset-mid-data then fetch addr=00000013");

    // Spurious mem_ready while idle
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk1("spur_if_ready", if_ready, 1'b0);
    chk1("spur_d_ready", d_ready, 1'b0);
    chk32("spur_if_rdata", if_rdata, 32'd0);
    chk32("spur_d_rdata", d_rdata, 32'd0);
    tick;
    mem_ready = 1'b0;
    #1;
    chk1("spur_busy", busy, 1'b0);
    chk1("spur_mem_req", mem_req, 1'b0);
    $display("txn spurious mem_ready ignored");

    // Randomized traffic against the transaction-level model
    m_owner = 0; m_streak = 0; lat_left = 0; done_if = 1'b0; done_d = 1'b0;
    e_addr = 32'd0; e_wdata = 32'd0; e_we = 1'b0; e_wstrb = 4'd0;
    for (int c = 0; c < 800; c++) begin
      tick;
      chk1("rnd_busy", busy, m_owner != 0);
      chk1("rnd_mem_req", mem_req, m_owner != 0);
      if (m_owner != 0) begin
        chk32("rnd_mem_addr", mem_addr, e_addr);
        chk1("rnd_mem_we", mem_we, e_we);
        chk32("rnd_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
        if (m_owner == 2) chk32("rnd_mem_wdata", mem_wdata, e_wdata);
      end

      if (m_owner != 0) begin
        mem_ready = (lat_left == 1);
        lat_left--;
      end else begin
        mem_ready = ($urandom_range(0, 7) == 0);
      end
      mem_rdata = $urandom;

      // Completed requesters release; the owner scrambles its inputs after grant.
      if (done_if) if_req = 1'b0;
      if (done_d) d_req = 1'b0;
      if (m_owner == 1) if_addr = $urandom;
      if (m_owner == 2) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_wstrb = 4'($urandom);
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom); d_wstrb = 4'($urandom);
      end
      #1;

      exp_if = (m_owner == 1) && mem_ready;
      exp_d  = (m_owner == 2) && mem_ready;
      chk1("rnd_if_ready", if_ready, exp_if);
      chk1("rnd_d_ready", d_ready, exp_d);
      chk32("rnd_if_rdata", if_rdata, exp_if ? mem_rdata : 32'd0);
      chk32("rnd_d_rdata", d_rdata, exp_d ? mem_rdata : 32'd0);
      if (exp_if || exp_d) begin
        $display("txn rnd %s addr=%h rdata=%h", exp_if ? "fetch" : "data", e_addr, mem_rdata);
      end
      done_if = exp_if;
      done_d  = exp_d;

      if (m_owner != 0) begin
        if (mem_ready) m_owner = 0;
      end else if (if_req || d_req) begin
        fetch_turn = if_req && (!d_req || m_streak >= MAXR);
        if (fetch_turn) begin
          m_owner = 1; e_addr = if_addr & ~32'd3; e_we = 1'b0; e_wstrb = 4'd0;
          m_streak = 0;
        end else begin
          m_owner = 2; e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
          e_wstrb = d_we ? d_wstrb : 4'd0;
          m_streak = if_req ? m_streak + 1 : 0;
        end
        lat_left = $urandom_range(1, 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
